// File: rtl/cg_delay_sched.sv
// Round-robin scheduler sharing one preset/stop/increment counter among NUM_REQ
// requesters; grants, presets, counts to the owner's delay and pulses its done.
module cg_delay_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_delay,
    input  logic                          i_pause,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_busy,
    output logic [DATA_WIDTH-1:0]         o_count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                state_q,  state_d;
    logic [PTR_W-1:0]      ptr_q,    ptr_d;
    logic [PTR_W-1:0]      owner_q,  owner_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] count_q,  count_d;
    logic [NUM_REQ-1:0]    gnt_q,    gnt_d;
    logic [NUM_REQ-1:0]    done_q,   done_d;
    logic                  busy_q,   busy_d;

    logic                  sel_found_c;
    logic [PTR_W-1:0]      sel_idx_c;

    // (base + off) mod NUM_REQ, with off < NUM_REQ
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned    off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // First pending request scanning from the round-robin pointer
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!sel_found_c && i_req[wrap_add(ptr_q, k)]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = wrap_add(ptr_q, k);
            end
        end
    end

    // Next-state, counter control and registered-output decode
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        target_d = target_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_found_c) begin
                    owner_d  = sel_idx_c;
                    target_d = i_delay[32'(sel_idx_c) * DATA_WIDTH +: DATA_WIDTH];
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!i_req[owner_q]) begin
                    ptr_d   = wrap_add(owner_q, 1);
                    state_d = ST_IDLE;
                end else begin
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Withdrawal wins over expiry; equality stops the count so it never wraps
                if (!i_req[owner_q]) begin
                    ptr_d   = wrap_add(owner_q, 1);
                    state_d = ST_IDLE;
                end else if (!i_pause) begin
                    if (count_q == target_q) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + DATA_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                ptr_d   = wrap_add(owner_q, 1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        gnt_d  = busy_d ? (NUM_REQ'(1) << owner_d) : '0;
        done_d = (state_d == ST_DONE) ? (NUM_REQ'(1) << owner_d) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            target_q <= '0;
            count_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_count = count_q;

endmodule
